// File: rtl/fw_pkg.sv
// Shared definitions for the blocked-IP table: command opcodes, the empty-entry
// value, the loader state encoding and the IP byte-order convention.
package fw_pkg;

   localparam logic [7:0]  OP_ADD      = 8'hA1;
   localparam logic [7:0]  OP_DEL      = 8'hA2;
   localparam logic [7:0]  OP_CLEAR    = 8'hA3;

   localparam logic [31:0] EMPTY_ENTRY = 32'h0000_0000;
   localparam int          IP_BYTES    = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_IDX,
      ST_GET_IP,
      ST_WRITE,
      ST_CLEAR
   } loaderState_t;

   typedef enum logic {
      CMD_ADD,
      CMD_DEL
   } cmdKind_t;

   // Network order: the first byte on the wire lands in bits [31:24], which the
   // filter's header extraction also assumes.
   function automatic logic [31:0] ipShiftIn(input logic [31:0] acc, input logic [7:0] nextByte);
      return {acc[23:0], nextByte};
   endfunction

endpackage

// File: rtl/blocklist_loader_frame_timeout.sv
// Loadable down-counter that flags an inter-byte gap inside a command frame.
module frame_timeout #(
   parameter int CNT_W = 20
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_loadValue,
   input  logic             i_run,
   output logic             o_expired
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadValue;
      end else if (i_run && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   // A fresh byte in the same cycle always wins over an expiry.
   assign o_expired = i_run && !i_load && (r_count == '0);

endmodule

// File: rtl/blocklist_loader.sv
// Parses ADD/DEL/CLEAR command frames from a byte stream and writes blocked-IP
// entries into the write port of the filter's dual-port table.
module blocklist_loader
   import fw_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 1_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        data_in,
   input  logic              valid_in,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_waddr,
   output logic [31:0]       bram_wdata,
   output logic              table_busy,
   output logic              ack,
   output logic              err
);

   localparam int                TMO_W        = $clog2(TIMEOUT + 1);
   // Loaded value is two short of TIMEOUT: one cycle for the load itself and one
   // for the registered err output. TIMEOUT must therefore be at least 2.
   localparam logic [TMO_W-1:0]  TMO_LOAD     = TMO_W'(TIMEOUT - 2);
   localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(DEPTH - 1);
   localparam logic [1:0]        LAST_IP_BYTE = 2'(IP_BYTES - 1);

   loaderState_t      r_state, w_nextState;
   cmdKind_t          r_cmd, w_nextCmd;
   logic [ADDR_W-1:0] r_idx, w_nextIdx;
   logic [31:0]       r_asm, w_nextAsm;
   logic [1:0]        r_ipCnt, w_nextIpCnt;
   logic [ADDR_W-1:0] r_clrCnt, w_nextClrCnt;

   logic              r_bramWe, w_nextWe;
   logic [ADDR_W-1:0] r_bramWaddr, w_nextWaddr;
   logic [31:0]       r_bramWdata, w_nextWdata;
   logic              r_tableBusy, w_nextBusy;
   logic              r_ack, w_nextAck;
   logic              r_err, w_nextErr;

   logic [ADDR_W-1:0] w_byteIdx;
   logic [ADDR_W-1:0] w_clrNext;
   logic [31:0]       w_asmShifted;
   logic              w_inFrame;
   logic              w_nextInFrame;
   logic              w_tmoExpired;

   assign w_byteIdx     = ADDR_W'(data_in);
   assign w_clrNext     = r_clrCnt + 1'b1;
   assign w_asmShifted  = ipShiftIn(r_asm, data_in);
   assign w_inFrame     = (r_state == ST_GET_IDX) || (r_state == ST_GET_IP);
   assign w_nextInFrame = (w_nextState == ST_GET_IDX) || (w_nextState == ST_GET_IP);

   frame_timeout #(
      .CNT_W (TMO_W)
   ) u_frameTimeout (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_clear     (!w_nextInFrame),
      .i_load      (valid_in && w_nextInFrame),
      .i_loadValue (TMO_LOAD),
      .i_run       (w_inFrame),
      .o_expired   (w_tmoExpired)
   );

   // State and every output are registered; the next-cycle output values are
   // decided alongside the next state so bram_we/ack/busy line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cmd       <= CMD_ADD;
         r_idx       <= '0;
         r_asm       <= '0;
         r_ipCnt     <= '0;
         r_clrCnt    <= '0;
         r_bramWe    <= 1'b0;
         r_bramWaddr <= '0;
         r_bramWdata <= '0;
         r_tableBusy <= 1'b0;
         r_ack       <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_cmd       <= w_nextCmd;
         r_idx       <= w_nextIdx;
         r_asm       <= w_nextAsm;
         r_ipCnt     <= w_nextIpCnt;
         r_clrCnt    <= w_nextClrCnt;
         r_bramWe    <= w_nextWe;
         r_bramWaddr <= w_nextWaddr;
         r_bramWdata <= w_nextWdata;
         r_tableBusy <= w_nextBusy;
         r_ack       <= w_nextAck;
         r_err       <= w_nextErr;
      end
   end

   always_comb begin
      w_nextState  = r_state;
      w_nextCmd    = r_cmd;
      w_nextIdx    = r_idx;
      w_nextAsm    = r_asm;
      w_nextIpCnt  = r_ipCnt;
      w_nextClrCnt = r_clrCnt;
      w_nextWe     = 1'b0;
      w_nextWaddr  = r_bramWaddr;
      w_nextWdata  = r_bramWdata;
      w_nextBusy   = 1'b0;
      w_nextAck    = 1'b0;
      w_nextErr    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (valid_in) begin
               case (data_in)
                  OP_ADD: begin
                     w_nextState = ST_GET_IDX;
                     w_nextCmd   = CMD_ADD;
                  end
                  OP_DEL: begin
                     w_nextState = ST_GET_IDX;
                     w_nextCmd   = CMD_DEL;
                  end
                  OP_CLEAR: begin
                     w_nextState  = ST_CLEAR;
                     w_nextClrCnt = '0;
                     w_nextWe     = 1'b1;
                     w_nextWaddr  = '0;
                     w_nextWdata  = EMPTY_ENTRY;
                     w_nextBusy   = 1'b1;
                     w_nextAck    = (LAST_ADDR == '0);
                  end
                  default: begin
                     w_nextErr = 1'b1;
                  end
               endcase
            end
         end

         ST_GET_IDX: begin
            if (valid_in) begin
               w_nextIdx = w_byteIdx;
               if (r_cmd == CMD_ADD) begin
                  w_nextState = ST_GET_IP;
                  w_nextIpCnt = '0;
                  w_nextAsm   = '0;
               end else begin
                  w_nextState = ST_WRITE;
                  w_nextWe    = 1'b1;
                  w_nextWaddr = w_byteIdx;
                  w_nextWdata = EMPTY_ENTRY;
                  w_nextBusy  = 1'b1;
                  w_nextAck   = 1'b1;
               end
            end else if (w_tmoExpired) begin
               w_nextState = ST_IDLE;
               w_nextErr   = 1'b1;
            end
         end

         ST_GET_IP: begin
            if (valid_in) begin
               w_nextAsm   = w_asmShifted;
               w_nextIpCnt = r_ipCnt + 1'b1;
               if (r_ipCnt == LAST_IP_BYTE) begin
                  w_nextState = ST_WRITE;
                  w_nextWe    = 1'b1;
                  w_nextWaddr = r_idx;
                  w_nextWdata = w_asmShifted;
                  w_nextBusy  = 1'b1;
                  w_nextAck   = 1'b1;
               end
            end else if (w_tmoExpired) begin
               w_nextState = ST_IDLE;
               w_nextErr   = 1'b1;
            end
         end

         ST_WRITE: begin
            w_nextState = ST_IDLE;
            w_nextErr   = valid_in;
         end

         // The clear counter tracks the address currently on the bus.
         ST_CLEAR: begin
            w_nextErr = valid_in;
            if (r_clrCnt == LAST_ADDR) begin
               w_nextState  = ST_IDLE;
               w_nextClrCnt = '0;
            end else begin
               w_nextClrCnt = w_clrNext;
               w_nextWe     = 1'b1;
               w_nextWaddr  = w_clrNext;
               w_nextWdata  = EMPTY_ENTRY;
               w_nextBusy   = 1'b1;
               w_nextAck    = (w_clrNext == LAST_ADDR);
            end
         end

         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   assign bram_we    = r_bramWe;
   assign bram_waddr = r_bramWaddr;
   assign bram_wdata = r_bramWdata;
   assign table_busy = r_tableBusy;
   assign ack        = r_ack;
   assign err        = r_err;

endmodule

// File: tb/tb_blocklist_loader.sv
// Directed bench for blocklist_loader: drives command frames, models the table
// contents from observed writes and compares against hand-computed values.
module tb_blocklist_loader;

   localparam int DEPTH   = 256;
   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 16;

   logic              clk;
   logic              rst_n;
   logic [7:0]        dataIn;
   logic              validIn;
   logic              bramWe;
   logic [ADDR_W-1:0] bramWaddr;
   logic [31:0]       bramWdata;
   logic              tableBusy;
   logic              ackOut;
   logic              errOut;

   int total;
   int bad;
   int cyc;
   int lastByteCyc;

   int weCount, ackCount, errCount, busyCount;
   int firstWeCyc, lastWeCyc, ackCyc, errCyc;
   int seqErr, busyMis, ackMis;
   logic [31:0] lastAddr, lastData;
   logic [31:0] mem [DEPTH];

   blocklist_loader #(
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (dataIn),
      .valid_in   (validIn),
      .bram_we    (bramWe),
      .bram_waddr (bramWaddr),
      .bram_wdata (bramWdata),
      .table_busy (tableBusy),
      .ack        (ackOut),
      .err        (errOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single point of comparison; every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 'h%0h, want 'h%0h", tag, observed, expected);
      end
   endtask

   task automatic clearStats();
      weCount = 0; ackCount = 0; errCount = 0; busyCount = 0;
      firstWeCyc = -1; lastWeCyc = -1; ackCyc = -1; errCyc = -1;
      seqErr = 0; busyMis = 0; ackMis = 0;
      lastAddr = '0; lastData = '0;
   endtask

   // Observes one cycle of outputs and folds it into the table model and stats.
   task automatic sampleOutputs();
      if (bramWe) begin
         if (bramWaddr != ADDR_W'(weCount)) seqErr++;
         if (weCount == 0) firstWeCyc = cyc;
         weCount++;
         lastWeCyc = cyc;
         lastAddr  = 32'(bramWaddr);
         lastData  = bramWdata;
         mem[bramWaddr] = bramWdata;
      end
      if (ackOut) begin
         ackCount++;
         ackCyc = cyc;
         if (!bramWe) ackMis++;
      end
      if (errOut) begin
         errCount++;
         errCyc = cyc;
      end
      if (tableBusy) busyCount++;
      if (tableBusy != bramWe) busyMis++;
   endtask

   // Called just after a rising edge; holds the inputs for exactly one cycle.
   task automatic stepCycle(input logic v, input logic [7:0] d);
      validIn = v;
      dataIn  = d;
      @(negedge clk);
      sampleOutputs();
      @(posedge clk);
      #1;
      cyc++;
      validIn = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle(1'b0, 8'h00);
   endtask

   task automatic applyStimulus(input logic [7:0] frame [6], input int len);
      for (int i = 0; i < len; i++) begin
         lastByteCyc = cyc;
         stepCycle(1'b1, frame[i]);
      end
   endtask

   task automatic checkSingleWrite(input string tag, input logic [31:0] expAddr, input logic [31:0] expData);
      checkOutput({tag, "_weCount"},  32'(weCount), 32'd1);
      checkOutput({tag, "_addr"},     lastAddr, expAddr);
      checkOutput({tag, "_data"},     lastData, expData);
      checkOutput({tag, "_weCycle"},  32'(lastWeCyc), 32'(lastByteCyc + 1));
      checkOutput({tag, "_ackCycle"}, 32'(ackCyc), 32'(lastByteCyc + 1));
      checkOutput({tag, "_busy"},     32'(busyCount), 32'd1);
   endtask

   initial begin
      logic [7:0] f [6];
      int opCyc;
      int nonZero;

      total = 0; bad = 0; cyc = 0; lastByteCyc = 0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'hFFFF_FFFF;
      clearStats();
      rst_n = 1'b0; validIn = 1'b0; dataIn = 8'h00;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_we",    32'(bramWe),    32'd0);
      checkOutput("rst_waddr", 32'(bramWaddr), 32'd0);
      checkOutput("rst_wdata", bramWdata,      32'd0);
      checkOutput("rst_busy",  32'(tableBusy), 32'd0);
      checkOutput("rst_ack",   32'(ackOut),    32'd0);
      checkOutput("rst_err",   32'(errOut),    32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idleCycles(3);

      $display("[TB] ADD to index 5");
      clearStats();
      f = '{8'hA1, 8'h05, 8'hC0, 8'hA8, 8'h01, 8'h0A};
      applyStimulus(f, 6);
      idleCycles(5);
      checkSingleWrite("add", 32'd5, 32'hC0A8_010A);
      checkOutput("add_ackCount", 32'(ackCount), 32'd1);
      checkOutput("add_errCount", 32'(errCount), 32'd0);

      $display("[TB] DEL index 5");
      clearStats();
      f = '{8'hA2, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
      applyStimulus(f, 2);
      idleCycles(5);
      checkSingleWrite("del", 32'd5, 32'h0);
      checkOutput("del_readback", mem[5], 32'h0);

      $display("[TB] CLEAR with bytes injected mid-clear");
      clearStats();
      opCyc = cyc;
      stepCycle(1'b1, 8'hA3);
      for (int i = 1; i <= DEPTH + 20; i++) begin
         if (i == 10)       stepCycle(1'b1, 8'hA1);
         else if (i == 100) stepCycle(1'b1, 8'h77);
         else               stepCycle(1'b0, 8'h00);
      end
      nonZero = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] != 32'h0) nonZero++;
      checkOutput("clr_weCount",   32'(weCount),    32'd256);
      checkOutput("clr_firstWe",   32'(firstWeCyc), 32'(opCyc + 1));
      checkOutput("clr_lastWe",    32'(lastWeCyc),  32'(opCyc + DEPTH));
      checkOutput("clr_addrSeq",   32'(seqErr),     32'd0);
      checkOutput("clr_ackCount",  32'(ackCount),   32'd1);
      checkOutput("clr_ackCycle",  32'(ackCyc),     32'(opCyc + DEPTH));
      checkOutput("clr_errCount",  32'(errCount),   32'd2);
      checkOutput("clr_busyCount", 32'(busyCount),  32'd256);
      checkOutput("clr_nonZero",   32'(nonZero),    32'd0);

      $display("[TB] bad opcode then ADD");
      clearStats();
      lastByteCyc = cyc;
      stepCycle(1'b1, 8'h55);
      idleCycles(3);
      checkOutput("bad_errCount", 32'(errCount), 32'd1);
      checkOutput("bad_errCycle", 32'(errCyc),   32'(lastByteCyc + 1));
      checkOutput("bad_weCount",  32'(weCount),  32'd0);
      clearStats();
      f = '{8'hA1, 8'h09, 8'h0A, 8'h00, 8'h00, 8'h01};
      applyStimulus(f, 6);
      idleCycles(4);
      checkSingleWrite("badAdd", 32'd9, 32'h0A00_0001);

      $display("[TB] inter-byte timeout");
      clearStats();
      f = '{8'hA1, 8'h07, 8'hC0, 8'h00, 8'h00, 8'h00};
      applyStimulus(f, 3);
      idleCycles(TIMEOUT + 10);
      checkOutput("tmo_errCount", 32'(errCount), 32'd1);
      checkOutput("tmo_errCycle", 32'(errCyc),   32'(lastByteCyc + TIMEOUT));
      checkOutput("tmo_weCount",  32'(weCount),  32'd0);
      clearStats();
      f = '{8'hA1, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04};
      applyStimulus(f, 6);
      idleCycles(4);
      checkSingleWrite("tmoAdd", 32'd7, 32'h0102_0304);

      $display("[TB] reset during ADD");
      clearStats();
      f = '{8'hA1, 8'h03, 8'h11, 8'h22, 8'h00, 8'h00};
      applyStimulus(f, 4);
      validIn = 1'b1;
      dataIn  = 8'h33;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_we",    32'(bramWe),    32'd0);
      checkOutput("midrst_busy",  32'(tableBusy), 32'd0);
      checkOutput("midrst_ack",   32'(ackOut),    32'd0);
      checkOutput("midrst_waddr", 32'(bramWaddr), 32'd0);
      checkOutput("midrst_wdata", bramWdata,      32'd0);
      repeat (3) @(posedge clk);
      #1;
      validIn = 1'b0;
      rst_n   = 1'b1;
      cyc++;
      idleCycles(TIMEOUT + 5);
      checkOutput("midrst_weCount",  32'(weCount),  32'd0);
      checkOutput("midrst_errCount", 32'(errCount), 32'd0);
      clearStats();
      f = '{8'hA1, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      applyStimulus(f, 6);
      idleCycles(4);
      checkSingleWrite("rstAdd", 32'd4, 32'hAABB_CCDD);
      checkOutput("final_busyMis", 32'(busyMis), 32'd0);
      checkOutput("final_ackMis",  32'(ackMis),  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
